rs_issue_scheduler: RTL and testbench

//  Owns occupancy and age state for the six distributed RS entries that dispatch fills.

---
 rtl/rs_sched_pkg.sv | 35 +++
 rtl/rs_issue_scheduler_if.sv | 34 +++
 rtl/rs_pair_select.sv | 24 ++
 rtl/rs_issue_scheduler.sv | 110 +++++++++++
 tb/tb_rs_issue_scheduler.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rs_sched_pkg.sv
// Shared constants and types for the RS issue scheduler: entry indices, age limits and the
// dispatch class encoding.
package rs_sched_pkg;

    localparam int unsigned NUM_ENTRIES = 6;
    localparam int unsigned NUM_PAIRS   = 3;

    localparam int unsigned IDX_COMPLEX0 = 5;
    localparam int unsigned IDX_COMPLEX1 = 4;
    localparam int unsigned IDX_SIMPLE0  = 3;
    localparam int unsigned IDX_SIMPLE1  = 2;
    localparam int unsigned IDX_FP0      = 1;
    localparam int unsigned IDX_FP1      = 0;

    localparam int unsigned AGE_W_DEFAULT = 3;
    localparam int unsigned AGE_MAX       = (1 << AGE_W_DEFAULT) - 1;

    // Matches the dispatch control encoding.
    typedef enum logic [1:0] {
        CLS_BUBBLE  = 2'b00,
        CLS_COMPLEX = 2'b01,
        CLS_FP      = 2'b10,
        CLS_SIMPLE  = 2'b11
    } rs_class_e;

    function automatic logic [2:0] popcount6(input logic [5:0] v);
        logic [2:0] cnt;
        cnt = '0;
        for (int i = 0; i < 6; i++) begin
            cnt = cnt + 3'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/rs_issue_scheduler_if.sv
// Dispatch/FU-facing signal bundle of the RS issue scheduler. The master side drives flush,
// allocation, operand readiness and FU readiness; the scheduler is the slave.
interface rs_issue_scheduler_if;

    logic       flush;
    logic [5:0] alloc_valid;
    logic [5:0] src_ready;
    logic       complex_fu_ready;
    logic       simple_fu_ready;
    logic       fp_fu_ready;

    logic [5:0] rs_empty;
    logic       complex_issue_valid;
    logic       complex_issue_sel;
    logic       simple_issue_valid;
    logic       simple_issue_sel;
    logic       fp_issue_valid;
    logic       fp_issue_sel;
    logic [2:0] rs_free_cnt;
    logic       sched_err;

    modport master (
        output flush, alloc_valid, src_ready, complex_fu_ready, simple_fu_ready, fp_fu_ready,
        input  rs_empty, complex_issue_valid, complex_issue_sel, simple_issue_valid,
               simple_issue_sel, fp_issue_valid, fp_issue_sel, rs_free_cnt, sched_err
    );

    modport slave (
        input  flush, alloc_valid, src_ready, complex_fu_ready, simple_fu_ready, fp_fu_ready,
        output rs_empty, complex_issue_valid, complex_issue_sel, simple_issue_valid,
               simple_issue_sel, fp_issue_valid, fp_issue_sel, rs_free_cnt, sched_err
    );

endinterface

// File: rtl/rs_pair_select.sv
// Oldest-first pick between the two entries of one FU class. Equal ages resolve to entry 1,
// which dispatch fills first on a same-cycle dual allocation.
module rs_pair_select #(
    parameter int unsigned AGE_W = 3
) (
    input  logic             busy0_i,
    input  logic             busy1_i,
    input  logic             ready0_i,
    input  logic             ready1_i,
    input  logic [AGE_W-1:0] age0_i,
    input  logic [AGE_W-1:0] age1_i,
    output logic             valid_o,
    output logic             sel_o
);

    logic cand0;
    logic cand1;

    assign cand0   = busy0_i & ready0_i;
    assign cand1   = busy1_i & ready1_i;
    assign valid_o = cand0 | cand1;
    assign sel_o   = cand1 & (~cand0 | (age1_i >= age0_i));

endmodule

// File: rtl/rs_issue_scheduler.sv
// Occupancy/age tracking for the six RS entries and per-class oldest-first issue selection
// with a valid/ready handshake to the complex, simple and FP units.
module rs_issue_scheduler
    import rs_sched_pkg::*;
#(
    parameter int unsigned AGE_W = AGE_W_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    rs_issue_scheduler_if.slave  bus
);

    localparam logic [AGE_W-1:0] AgeMax = {AGE_W{1'b1}};

    logic [NUM_ENTRIES-1:0] busy_q, busy_d;
    logic [AGE_W-1:0]       age_q [NUM_ENTRIES];
    logic [AGE_W-1:0]       age_d [NUM_ENTRIES];
    logic                   err_q, err_d;

    // Pair vectors are indexed {complex, simple, fp} = [2:0].
    logic [NUM_PAIRS-1:0]   pair_valid;
    logic [NUM_PAIRS-1:0]   pair_sel;
    logic [NUM_PAIRS-1:0]   issue_valid;
    logic [NUM_PAIRS-1:0]   fu_ready;
    logic [NUM_PAIRS-1:0]   xfer;
    logic [NUM_ENTRIES-1:0] issue_clr;
    logic [NUM_ENTRIES-1:0] alloc_ok;
    logic [NUM_ENTRIES-1:0] alloc_bad;

    // Pair p owns entries 2p+1 (entry 0 of the pair) and 2p (entry 1).
    for (genvar p = 0; p < NUM_PAIRS; p++) begin : g_pair
        rs_pair_select #(
            .AGE_W (AGE_W)
        ) u_pair_select (
            .busy0_i  (busy_q[2*p+1]),
            .busy1_i  (busy_q[2*p]),
            .ready0_i (bus.src_ready[2*p+1]),
            .ready1_i (bus.src_ready[2*p]),
            .age0_i   (age_q[2*p+1]),
            .age1_i   (age_q[2*p]),
            .valid_o  (pair_valid[p]),
            .sel_o    (pair_sel[p])
        );
    end

    assign fu_ready    = {bus.complex_fu_ready, bus.simple_fu_ready, bus.fp_fu_ready};
    assign issue_valid = pair_valid & {NUM_PAIRS{~bus.flush}};
    assign xfer        = issue_valid & fu_ready;
    assign alloc_ok    = bus.alloc_valid & ~busy_q;
    assign alloc_bad   = bus.alloc_valid & busy_q;

    always_comb begin
        issue_clr = '0;
        for (int p = 0; p < NUM_PAIRS; p++) begin
            issue_clr[2*p]   = xfer[p] & pair_sel[p];
            issue_clr[2*p+1] = xfer[p] & ~pair_sel[p];
        end
    end

    always_comb begin
        busy_d = busy_q;
        age_d  = age_q;
        err_d  = err_q;
        if (bus.flush) begin
            // Same-cycle allocations are dropped and never count as errors.
            busy_d = '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                age_d[i] = '0;
            end
        end else begin
            err_d = err_q | (|alloc_bad);
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (alloc_ok[i]) begin
                    busy_d[i] = 1'b1;
                    age_d[i]  = '0;
                end else if (issue_clr[i]) begin
                    busy_d[i] = 1'b0;
                    age_d[i]  = '0;
                end else if (busy_q[i] && (age_q[i] != AgeMax)) begin
                    age_d[i] = age_q[i] + AGE_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            err_q  <= 1'b0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            busy_q <= busy_d;
            err_q  <= err_d;
            age_q  <= age_d;
        end
    end

    assign bus.rs_empty            = ~busy_q;
    assign bus.rs_free_cnt         = popcount6(~busy_q);
    assign bus.sched_err           = err_q;
    assign bus.complex_issue_valid = issue_valid[2];
    assign bus.complex_issue_sel   = pair_sel[2];
    assign bus.simple_issue_valid  = issue_valid[1];
    assign bus.simple_issue_sel    = pair_sel[1];
    assign bus.fp_issue_valid      = issue_valid[0];
    assign bus.fp_issue_sel        = pair_sel[0];

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Bench for rs_issue_scheduler: directed vector table, a saturation sequence on an AGE_W=1
// instance, and randomized traffic against a timestamp-based reference model.
module tb_rs_issue_scheduler;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    rs_issue_scheduler_if if0 ();
    rs_issue_scheduler_if if1 ();

    rs_issue_scheduler #(.AGE_W(3)) u_dut  (.clk(clk), .rst(rst), .bus(if0));
    rs_issue_scheduler #(.AGE_W(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));

    typedef struct {
        logic       rst;
        logic       flush;
        logic [5:0] alloc;
        logic [5:0] srdy;
        logic [2:0] fu;
        logic       chk;
        logic [5:0] e_empty;
        logic [2:0] e_free;
        logic [2:0] e_valid;
        logic [2:0] e_sel;
        logic       e_err;
    } vec_t;

    vec_t vq[$];

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: entries hold the cycle at which they became visible; age is elapsed
    // time clipped at the counter maximum.
    localparam int AMAX0 = (1 << 3) - 1;
    bit m_busy [6];
    int m_t    [6];
    bit m_err;
    bit m_ok;
    int now;

    // Directed expectations for the current cycle.
    logic       t_chk;
    logic [5:0] t_empty;
    logic [2:0] t_free;
    logic [2:0] t_valid, t_sel;
    logic       t_err;

    // Expectations for the AGE_W=1 instance.
    logic chk1, e1_valid, e1_sel;

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, now);
    endtask

    function automatic logic [5:0] model_busy_mask();
        logic [5:0] m;
        for (int e = 0; e < 6; e++) m[e] = m_busy[e];
        return m;
    endfunction

    task automatic cycle(input logic r, input logic f, input logic [5:0] al,
                         input logic [5:0] sr, input logic [2:0] fu);
        logic [2:0] ev, es;
        logic [5:0] eempty;
        int         nfree;
        bit         pre [6];
        @(negedge clk);
        rst                  = r;
        if0.flush            = f;
        if0.alloc_valid      = al;
        if0.src_ready        = sr;
        if0.complex_fu_ready = fu[2];
        if0.simple_fu_ready  = fu[1];
        if0.fp_fu_ready      = fu[0];
        #1;
        nfree = 0;
        for (int e = 0; e < 6; e++) begin
            eempty[e] = !m_busy[e];
            if (!m_busy[e]) nfree++;
        end
        for (int p = 0; p < 3; p++) begin
            int  a0, a1;
            bit  c0, c1;
            c0 = m_busy[2*p+1] && sr[2*p+1];
            c1 = m_busy[2*p] && sr[2*p];
            a0 = now - m_t[2*p+1];
            a1 = now - m_t[2*p];
            if (a0 > AMAX0) a0 = AMAX0;
            if (a1 > AMAX0) a1 = AMAX0;
            ev[p] = (c0 || c1) && !f;
            if (c0 && c1) es[p] = (a1 >= a0);
            else          es[p] = c1;
        end
        if (m_ok) begin
            check("model_empty", 8'(if0.rs_empty), 8'(eempty));
            check("model_free", 8'(if0.rs_free_cnt), 8'(nfree));
            check("model_valid", 8'({if0.complex_issue_valid, if0.simple_issue_valid,
                                      if0.fp_issue_valid}), 8'(ev));
            check("model_sel", 8'({if0.complex_issue_sel, if0.simple_issue_sel,
                                    if0.fp_issue_sel}), 8'(es));
            check("model_err", 8'(if0.sched_err), 8'(m_err));
        end
        if (t_chk) begin
            check("vec_empty", 8'(if0.rs_empty), 8'(t_empty));
            check("vec_free", 8'(if0.rs_free_cnt), 8'(t_free));
            check("vec_valid", 8'({if0.complex_issue_valid, if0.simple_issue_valid,
                                    if0.fp_issue_valid}), 8'(t_valid));
            check("vec_sel", 8'({if0.complex_issue_sel, if0.simple_issue_sel,
                                  if0.fp_issue_sel}), 8'(t_sel));
            check("vec_err", 8'(if0.sched_err), 8'(t_err));
        end
        if (chk1) begin
            check("sat_fp_valid", 8'(if1.fp_issue_valid), 8'(e1_valid));
            check("sat_fp_sel", 8'(if1.fp_issue_sel), 8'(e1_sel));
        end
        @(posedge clk);
        for (int e = 0; e < 6; e++) pre[e] = m_busy[e];
        if (r) begin
            for (int e = 0; e < 6; e++) begin
                m_busy[e] = 0;
                m_t[e]    = 0;
            end
            m_err = 0;
            m_ok  = 1;
        end else if (f) begin
            for (int e = 0; e < 6; e++) m_busy[e] = 0;
        end else begin
            for (int e = 0; e < 6; e++) if (al[e] && pre[e]) m_err = 1;
            for (int p = 0; p < 3; p++) begin
                if (ev[p] && fu[p]) m_busy[es[p] ? 2*p : 2*p+1] = 0;
            end
            for (int e = 0; e < 6; e++) begin
                if (al[e] && !pre[e]) begin
                    m_busy[e] = 1;
                    m_t[e]    = now + 1;
                end
            end
        end
        now++;
        #1;
    endtask

    task automatic add(input logic r, input logic f, input logic [5:0] al, input logic [5:0] sr,
                       input logic [2:0] fu, input logic chk, input logic [5:0] emp,
                       input logic [2:0] fr, input logic [2:0] v, input logic [2:0] s,
                       input logic err);
        vec_t x;
        x.rst = r; x.flush = f; x.alloc = al; x.srdy = sr; x.fu = fu; x.chk = chk;
        x.e_empty = emp; x.e_free = fr; x.e_valid = v; x.e_sel = s; x.e_err = err;
        vq.push_back(x);
    endtask

    initial begin
        rst = 1'b1;
        if0.flush = 1'b0; if0.alloc_valid = '0; if0.src_ready = '0;
        if0.complex_fu_ready = 1'b0; if0.simple_fu_ready = 1'b0; if0.fp_fu_ready = 1'b0;
        if1.flush = 1'b0; if1.alloc_valid = '0; if1.src_ready = '0;
        if1.complex_fu_ready = 1'b0; if1.simple_fu_ready = 1'b0; if1.fp_fu_ready = 1'b0;
        m_ok = 0; m_err = 0; now = 0; t_chk = 0; chk1 = 0; e1_valid = 0; e1_sel = 0;
        for (int e = 0; e < 6; e++) begin m_busy[e] = 0; m_t[e] = 0; end

        //  rst flush alloc     srdy      fu      chk empty     free  valid   sel     err
        // reset
        add(1, 0, 6'b000000, 6'b000000, 3'b000, 0, 6'h3f, 3'd6, 3'b000, 3'b000, 0);
        add(1, 0, 6'b000000, 6'b000000, 3'b000, 1, 6'h3f, 3'd6, 3'b000, 3'b000, 0);
        // alloc fp1 then issue
        add(0, 0, 6'b000001, 6'b000000, 3'b001, 1, 6'h3f, 3'd6, 3'b000, 3'b000, 0);
        add(0, 0, 6'b000000, 6'b000001, 3'b001, 1, 6'h3e, 3'd5, 3'b001, 3'b001, 0);
        add(0, 0, 6'b000000, 6'b000001, 3'b001, 1, 6'h3f, 3'd6, 3'b000, 3'b000, 0);
        // age order: simple1 then simple0
        add(0, 0, 6'b000100, 6'b000000, 3'b010, 1, 6'h3f, 3'd6, 3'b000, 3'b000, 0);
        add(0, 0, 6'b000000, 6'b000000, 3'b010, 1, 6'h3b, 3'd5, 3'b000, 3'b000, 0);
        add(0, 0, 6'b001000, 6'b000000, 3'b010, 1, 6'h3b, 3'd5, 3'b000, 3'b000, 0);
        add(0, 0, 6'b000000, 6'b000000, 3'b010, 1, 6'h33, 3'd4, 3'b000, 3'b000, 0);
        add(0, 0, 6'b000000, 6'b001100, 3'b010, 1, 6'h33, 3'd4, 3'b010, 3'b010, 0);
        add(0, 0, 6'b000000, 6'b001100, 3'b010, 1, 6'h37, 3'd5, 3'b010, 3'b000, 0);
        add(0, 0, 6'b000000, 6'b000000, 3'b000, 1, 6'h3f, 3'd6, 3'b000, 3'b000, 0);
        // backpressure on complex1
        add(0, 0, 6'b010000, 6'b000000, 3'b000, 1, 6'h3f, 3'd6, 3'b000, 3'b000, 0);
        add(0, 0, 6'b000000, 6'b010000, 3'b000, 1, 6'h2f, 3'd5, 3'b100, 3'b100, 0);
        add(0, 0, 6'b000000, 6'b010000, 3'b000, 1, 6'h2f, 3'd5, 3'b100, 3'b100, 0);
        add(0, 0, 6'b000000, 6'b010000, 3'b000, 1, 6'h2f, 3'd5, 3'b100, 3'b100, 0);
        add(0, 0, 6'b000000, 6'b010000, 3'b100, 1, 6'h2f, 3'd5, 3'b100, 3'b100, 0);
        add(0, 0, 6'b000000, 6'b010000, 3'b000, 1, 6'h3f, 3'd6, 3'b000, 3'b000, 0);
        // flush with a dropped alloc, then sticky error
        add(0, 0, 6'b111111, 6'b000000, 3'b000, 1, 6'h3f, 3'd6, 3'b000, 3'b000, 0);
        add(0, 1, 6'b000011, 6'b111111, 3'b111, 1, 6'h00, 3'd0, 3'b000, 3'b111, 0);
        add(0, 0, 6'b000000, 6'b000000, 3'b000, 1, 6'h3f, 3'd6, 3'b000, 3'b000, 0);
        add(0, 0, 6'b000010, 6'b000000, 3'b000, 1, 6'h3f, 3'd6, 3'b000, 3'b000, 0);
        add(0, 0, 6'b000010, 6'b000000, 3'b000, 1, 6'h3d, 3'd5, 3'b000, 3'b000, 0);
        add(0, 0, 6'b000000, 6'b000000, 3'b000, 1, 6'h3d, 3'd5, 3'b000, 3'b000, 1);
        add(0, 1, 6'b000000, 6'b000000, 3'b000, 1, 6'h3d, 3'd5, 3'b000, 3'b000, 1);
        add(0, 0, 6'b000000, 6'b000000, 3'b000, 1, 6'h3f, 3'd6, 3'b000, 3'b000, 1);
        add(1, 0, 6'b000000, 6'b000000, 3'b000, 1, 6'h3f, 3'd6, 3'b000, 3'b000, 1);
        add(0, 0, 6'b000000, 6'b000000, 3'b000, 1, 6'h3f, 3'd6, 3'b000, 3'b000, 0);

        foreach (vq[k]) begin
            t_chk = vq[k].chk; t_empty = vq[k].e_empty; t_free = vq[k].e_free;
            t_valid = vq[k].e_valid; t_sel = vq[k].e_sel; t_err = vq[k].e_err;
            cycle(vq[k].rst, vq[k].flush, vq[k].alloc, vq[k].srdy, vq[k].fu);
        end
        t_chk = 0;

        // Saturation tie on the AGE_W=1 instance: fp0 is older, but once both ages clip
        // to 1 the tie goes to fp1.
        if1.alloc_valid = 6'b000010;
        cycle(0, 0, '0, '0, '0);
        if1.alloc_valid = 6'b000001; if1.src_ready = 6'b000011;
        chk1 = 1; e1_valid = 1; e1_sel = 0;
        cycle(0, 0, '0, '0, '0);
        if1.alloc_valid = '0;
        cycle(0, 0, '0, '0, '0);
        e1_sel = 1;
        cycle(0, 0, '0, '0, '0);
        cycle(0, 0, '0, '0, '0);
        cycle(0, 0, '0, '0, '0);
        if1.fp_fu_ready = 1'b1;
        cycle(0, 0, '0, '0, '0);
        e1_sel = 0;
        cycle(0, 0, '0, '0, '0);
        e1_valid = 0;
        cycle(0, 0, '0, '0, '0);
        chk1 = 0;
        if1.src_ready = '0; if1.fp_fu_ready = 1'b0;

        for (int n = 0; n < 1500; n++) begin
            logic       r, f;
            logic [5:0] al, sr;
            logic [2:0] fu;
            r  = ($urandom_range(0, 199) == 0);
            f  = ($urandom_range(0, 39) == 0);
            al = 6'($urandom) & 6'($urandom);
            if ($urandom_range(0, 15) != 0) al = al & ~model_busy_mask();
            sr = 6'($urandom);
            fu = 3'($urandom) | 3'($urandom);
            cycle(r, f, al, sr, fu);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
